pixie_dma_server: RTL

// - Memory-side responder for the CDP1861 (Pixie) DMA-out request line DMAO.
// - On each request it fetches BURST_LEN bytes from shared RAM, starting at a
//   CPU-loaded R0 pointer, and hands each byte to the video front end with a

---
 rtl/rcastudioii_pkg.sv | 13 +
 rtl/dma_addr_ctr.sv | 50 +++++
 rtl/pixie_dma_server.sv | 114 +++++++++++
 3 files changed

// File: rtl/rcastudioii_pkg.sv
// Shared types and constants for the RCA Studio II video/DMA slice.
package rcastudioii_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        WAITQ   = 2'd2,
        DELIVER = 2'd3
    } dma_state_t;

    localparam logic [15:0] DISPLAY_BASE = 16'h0900;

endpackage

// File: rtl/dma_addr_ctr.sv
// R0 display pointer: increments per delivered byte and defers CPU loads
// that arrive mid-burst so one burst always reads a contiguous address run.
module dma_addr_ctr #(
    parameter int AW = 16
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          r0_load,
    input  logic [AW-1:0] r0_din,
    input  logic          busy,
    input  logic          advance,
    input  logic          burst_end,
    output logic [AW-1:0] r0_q
);

    logic          pend_load;
    logic [AW-1:0] pend_addr;

    // A load arriving on the closing handshake beats both the pending value
    // and the increment. CPU loads are not gated by ce so a strobe is never lost.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r0_q      <= '0;
            pend_load <= 1'b0;
            pend_addr <= '0;
        end else if (burst_end) begin
            if (r0_load) begin
                r0_q <= r0_din;
            end else if (pend_load) begin
                r0_q <= pend_addr;
            end else begin
                r0_q <= r0_q + 1'b1;
            end
            pend_load <= 1'b0;
        end else begin
            if (advance) begin
                r0_q <= r0_q + 1'b1;
            end
            if (r0_load) begin
                if (busy) begin
                    pend_load <= 1'b1;
                    pend_addr <= r0_din;
                end else begin
                    r0_q <= r0_din;
                end
            end
        end
    end

endmodule

// File: rtl/pixie_dma_server.sv
// Answers Pixie DMAO requests: fetches BURST_LEN bytes from RAM at R0 and
// hands them to video over valid/ready, stalling the CPU for the burst.
module pixie_dma_server
    import rcastudioii_pkg::*;
#(
    parameter int AW        = 16,
    parameter int BURST_LEN = 8,
    parameter int RAM_LAT   = 1
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ce,
    input  logic          dma_req,
    input  logic          r0_load,
    input  logic [AW-1:0] r0_din,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_q,
    output logic [7:0]    vid_data,
    output logic          vid_valid,
    input  logic          vid_ready,
    output logic          cpu_stall,
    output logic [AW-1:0] r0_q
);

    localparam int            CW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(BURST_LEN - 1);
    localparam logic [1:0]    LAT_INIT  = 2'(RAM_LAT - 1);

    dma_state_t    state;
    dma_state_t    state_next;
    logic [CW-1:0] byte_cnt;
    logic [1:0]    lat_cnt;
    logic          accept;
    logic          last_byte;
    logic          burst_end;
    logic          busy;

    // Ending early on a dropped request still finishes the byte in flight.
    assign accept    = ce && (state == DELIVER) && vid_ready;
    assign last_byte = (byte_cnt == LAST_BYTE) || !dma_req;
    assign burst_end = accept && last_byte;
    assign busy      = (state != IDLE);
    assign mem_addr  = r0_q;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state <= IDLE;
        end else if (ce) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (dma_req) state_next = FETCH;
            FETCH:   state_next = WAITQ;
            WAITQ:   if (lat_cnt == 2'd0) state_next = DELIVER;
            DELIVER: if (vid_ready) state_next = last_byte ? IDLE : FETCH;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_rd    = (state == FETCH);
        cpu_stall = (state != IDLE);
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            byte_cnt  <= '0;
            lat_cnt   <= 2'd0;
            vid_data  <= 8'd0;
            vid_valid <= 1'b0;
        end else if (ce) begin
            case (state)
                IDLE: begin
                    if (dma_req) byte_cnt <= '0;
                end
                FETCH: begin
                    lat_cnt <= LAT_INIT;
                end
                WAITQ: begin
                    if (lat_cnt == 2'd0) begin
                        vid_data  <= mem_q;
                        vid_valid <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                DELIVER: begin
                    if (vid_ready) begin
                        vid_valid <= 1'b0;
                        byte_cnt  <= byte_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    dma_addr_ctr #(.AW(AW)) u_addr_ctr (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .r0_load   (r0_load),
        .r0_din    (r0_din),
        .busy      (busy),
        .advance   (accept),
        .burst_end (burst_end),
        .r0_q      (r0_q)
    );

endmodule
